// File: rtl/rr_selector.sv
// Round-robin output selector for one crossbar output port.
// Locks onto a multi-flit packet until its tail flit transfers.
module rr_selector #(
  parameter int N_IN  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req,
  input  logic [N_IN-1:0]  tail,
  input  logic             out_ready,
  output logic [N_IN-1:0]  select,
  output logic             valid,
  output logic             locked,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_IN - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] owner, owner_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] win, cur;
  logic          found, xfer, done;

  // Circular first-set search starting at ptr.
  always_comb begin : arb
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_IN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    cur    = (state == LOCKED) ? owner : win;
    select = '0;
    if (state == LOCKED || found) select[cur] = 1'b1;
    valid  = |(select & req);
    xfer   = valid & out_ready;
    done   = xfer & tail[cur];
    locked = (state == LOCKED);
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (xfer && !tail[cur]) begin
          state_nxt = LOCKED;
          owner_nxt = cur;
        end
      end
      LOCKED: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (done) ptr_nxt = (cur == LAST) ? '0 : cur + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      pkt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      ptr     <= ptr_nxt;
      pkt_cnt <= pkt_cnt + CNT_W'(done);
    end
  end

endmodule

// File: tb/tb_rr_selector.sv
// Bench for rr_selector: directed table, corner sequences, random vs model.
// Two instances share stimulus; the second has a 4-bit packet counter.
module tb_rr_selector;

  logic        clk;
  logic        rst_n;
  logic [4:0]  req, tail;
  logic        out_ready;
  logic [4:0]  select, select4;
  logic        valid, valid4, locked, locked4;
  logic [15:0] pkt_cnt;
  logic [3:0]  pkt_cnt4;

  int errors = 0;
  int checks = 0;

  bit mlocked;
  int mowner, mptr, mcnt;

  rr_selector #(.N_IN(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .tail(tail),
    .out_ready(out_ready), .select(select), .valid(valid),
    .locked(locked), .pkt_cnt(pkt_cnt)
  );

  rr_selector #(.N_IN(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .tail(tail),
    .out_ready(out_ready), .select(select4), .valid(valid4),
    .locked(locked4), .pkt_cnt(pkt_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] r;
    logic [4:0] t;
    logic       o;
    logic [4:0] s;
    logic       v;
    logic       l;
    int         c;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Reference: rotate req so ptr sits at bit 0, take lowest set bit.
  function automatic logic [4:0] model_sel();
    logic [9:0] dbl;
    logic [4:0] rot;
    if (mlocked) return 5'(1 << mowner);
    dbl = {req, req} >> mptr;
    rot = dbl[4:0];
    for (int k = 0; k < 5; k++)
      if (rot[k]) return 5'(1 << ((k + mptr) % 5));
    return 5'b0;
  endfunction

  task automatic model_reset();
    mlocked = 1'b0;
    mowner  = 0;
    mptr    = 0;
    mcnt    = 0;
  endtask

  task automatic apply(input logic [4:0] r, input logic [4:0] t,
                       input logic o);
    req       = r;
    tail      = t;
    out_ready = o;
    #1;
  endtask

  task automatic tick();
    logic [4:0] s;
    int w;
    s = model_sel();
    w = 0;
    for (int k = 0; k < 5; k++) if (s[k]) w = k;
    if (rst_n && |(s & req) && out_ready) begin
      if (tail[w]) begin
        mlocked = 1'b0;
        mptr    = (w + 1) % 5;
        mcnt++;
      end else if (!mlocked) begin
        mlocked = 1'b1;
        mowner  = w;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string nm);
    logic [4:0] s;
    s = model_sel();
    chk({nm, " select"}, 32'(select), 32'(s));
    chk({nm, " valid"}, 32'(valid), 32'(|(s & req)));
    chk({nm, " locked"}, 32'(locked), 32'(mlocked));
    chk({nm, " pkt_cnt"}, 32'(pkt_cnt), 32'(mcnt % 65536));
    chk({nm, " pkt_cnt4"}, 32'(pkt_cnt4), 32'(mcnt % 16));
    chk({nm, " select4"}, 32'(select4), 32'(s));
  endtask

  initial begin
    // test 1: round robin on single-flit packets
    tbl[0]  = '{5'b10100, 5'b11111, 1'b1, 5'b00100, 1'b1, 1'b0, 0};
    tbl[1]  = '{5'b10100, 5'b11111, 1'b1, 5'b10000, 1'b1, 1'b0, 1};
    tbl[2]  = '{5'b10100, 5'b11111, 1'b1, 5'b00100, 1'b1, 1'b0, 2};
    tbl[3]  = '{5'b00001, 5'b11111, 1'b1, 5'b00001, 1'b1, 1'b0, 3};
    // test 2: 3-flit packet from input 1
    tbl[4]  = '{5'b01011, 5'b00000, 1'b1, 5'b00010, 1'b1, 1'b0, 4};
    tbl[5]  = '{5'b01011, 5'b00000, 1'b1, 5'b00010, 1'b1, 1'b1, 4};
    tbl[6]  = '{5'b01011, 5'b00010, 1'b1, 5'b00010, 1'b1, 1'b1, 4};
    tbl[7]  = '{5'b01011, 5'b00000, 1'b0, 5'b01000, 1'b1, 1'b0, 5};
    // test 3: owner 2 drops req for 4 cycles
    tbl[8]  = '{5'b00101, 5'b00000, 1'b1, 5'b00100, 1'b1, 1'b0, 5};
    tbl[9]  = '{5'b00001, 5'b00000, 1'b1, 5'b00100, 1'b0, 1'b1, 5};
    tbl[10] = '{5'b00001, 5'b00000, 1'b1, 5'b00100, 1'b0, 1'b1, 5};
    tbl[11] = '{5'b00001, 5'b00000, 1'b1, 5'b00100, 1'b0, 1'b1, 5};
    tbl[12] = '{5'b00001, 5'b00000, 1'b1, 5'b00100, 1'b0, 1'b1, 5};
    // test 4: out_ready low for 3 cycles while locked
    tbl[13] = '{5'b00101, 5'b00000, 1'b1, 5'b00100, 1'b1, 1'b1, 5};
    tbl[14] = '{5'b00101, 5'b00100, 1'b0, 5'b00100, 1'b1, 1'b1, 5};
    tbl[15] = '{5'b00101, 5'b00100, 1'b0, 5'b00100, 1'b1, 1'b1, 5};
    tbl[16] = '{5'b00101, 5'b00100, 1'b0, 5'b00100, 1'b1, 1'b1, 5};
    tbl[17] = '{5'b00101, 5'b00100, 1'b1, 5'b00100, 1'b1, 1'b1, 5};
    tbl[18] = '{5'b00101, 5'b00000, 1'b0, 5'b00001, 1'b1, 1'b0, 6};
    tbl[19] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 6};

    rst_n = 1'b0;
    model_reset();
    apply(5'b0, 5'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset locked", 32'(locked), 32'd0);
    chk("reset pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("reset idle select", 32'(select), 32'd0);
    chk("reset idle valid", 32'(valid), 32'd0);
    apply(5'b00110, 5'b11111, 1'b1);
    chk("reset select ptr0", 32'(select), 32'b00010);
    @(posedge clk);
    #1;
    chk("reset no count", 32'(pkt_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].r, tbl[i].t, tbl[i].o);
      chk($sformatf("vec%0d select", i), 32'(select), 32'(tbl[i].s));
      chk($sformatf("vec%0d valid", i), 32'(valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d locked", i), 32'(locked), 32'(tbl[i].l));
      chk($sformatf("vec%0d pkt_cnt", i), 32'(pkt_cnt), 32'(tbl[i].c));
      tick();
    end

    // test 5: reset in the middle of a packet from input 4
    apply(5'b10000, 5'b00000, 1'b1);
    check_model("t5 head");
    tick();
    apply(5'b10000, 5'b00000, 1'b1);
    chk("t5 locked", 32'(locked), 32'd1);
    tick();
    req   = 5'b11111;
    rst_n = 1'b0;
    #1;
    chk("t5 async locked", 32'(locked), 32'd0);
    chk("t5 async pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("t5 async select", 32'(select), 32'b00001);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(5'b11111, 5'b11111, 1'b1);
    chk("t5 restart select", 32'(select), 32'b00001);
    tick();
    apply(5'b11111, 5'b11111, 1'b1);
    chk("t5 next select", 32'(select), 32'b00010);

    // test 6: 16 single-flit packets wrap the 4-bit counter
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply(5'b11111, 5'b11111, 1'b1);
      chk($sformatf("t6 cnt4 %0d", i), 32'(pkt_cnt4), 32'(i));
      chk($sformatf("t6 sel %0d", i), 32'(select), 32'(1 << (i % 5)));
      tick();
    end
    apply(5'b11111, 5'b11111, 1'b0);
    chk("t6 wrap cnt4", 32'(pkt_cnt4), 32'd0);
    chk("t6 cnt16", 32'(pkt_cnt), 32'd16);
    chk("t6 locked", 32'(locked4), 32'd0);
    chk("t6 ptr select", 32'(select4), 32'b00010);
    tick();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] r, t;
      r = 5'($urandom);
      t = 5'($urandom) & 5'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        req   = r;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rand async locked", 32'(locked), 32'd0);
        chk("rand async cnt", 32'(pkt_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      apply(r, t, $urandom_range(0, 3) != 0);
      check_model($sformatf("rand%0d", i));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_selector.md
RR_SELECTOR -- requirements
Module: rr_selector

Interface
REQ-001 Parameter N_IN, default 5: number of requesting input ports, legal range 2..16.
REQ-002 Parameter CNT_W, default 16: width of the completed-packet counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N_IN  per-input request; bit i high means input i holds a flit for this output.
REQ-006 tail  input  N_IN  per-input tail marker; bit i is meaningful only while req[i] is high.
REQ-007 out_ready  input  1  downstream can accept a flit this cycle.
REQ-008 select  output  N_IN  one-hot crossbar select for this output port; all-zero when idle.
REQ-009 valid  output  1  a flit is presented this cycle; equals the OR of (select AND req).
REQ-010 locked  output  1  high while a multi-flit packet owns the output.
REQ-011 pkt_cnt  output  CNT_W  count of completed packets.

Function
REQ-012 A transfer SHALL occur in a cycle when valid and out_ready are both high.
REQ-013 The FSM SHALL have two states: IDLE and LOCKED. It SHALL hold a registered owner index, log2(N_IN) bits, and a registered round-robin pointer ptr with range 0..N_IN-1.
REQ-014 In IDLE, select SHALL be combinational and one-hot on the first set req bit, searching circularly from ptr upward: ptr, ptr+1, ..., wrapping N_IN-1 -> 0.
REQ-015 In IDLE with req all-zero, select SHALL be all-zero and valid SHALL be 0. Outputs are never X.
REQ-016 In IDLE, on a transfer by winner w:
 - tail[w]=0: next state LOCKED, owner <= w.
 - tail[w]=1 (single-flit packet): stay IDLE, ptr <= (w+1) mod N_IN, pkt_cnt increments.
REQ-017 In LOCKED, select SHALL be one-hot on owner regardless of the other req bits, and valid SHALL equal req[owner].
REQ-018 In LOCKED, a deasserted req[owner] SHALL keep the lock; the block stalls with no timeout.
REQ-019 In LOCKED, on a transfer with tail[owner]=1: next state IDLE, ptr <= (owner+1) mod N_IN, pkt_cnt increments. The next arbitration therefore starts in the following cycle (one-cycle turnaround).
REQ-020 In LOCKED, a transfer with tail[owner]=0 SHALL leave state, owner and ptr unchanged.
REQ-021 With out_ready=0, the FSM state, owner, ptr and pkt_cnt SHALL hold, and select SHALL still be driven per REQ-014 and REQ-017.
REQ-022 ptr SHALL change only on packet completion, never on a non-tail transfer or on a stall.
REQ-023 pkt_cnt SHALL wrap modulo 2^CNT_W, from all-ones to 0.
REQ-024 locked SHALL be high exactly when the state is LOCKED.
REQ-025 req bits that drop and re-rise while another input is locked SHALL not affect arbitration order.

Reset
REQ-026 While rst_n=0: state=IDLE, owner=0, ptr=0, pkt_cnt=0, locked=0. select and valid follow REQ-014 and REQ-015 with ptr=0.
REQ-027 Reset asserted mid-packet SHALL abort the lock immediately, without waiting for a clock edge. After release, arbitration restarts from input 0.
REQ-028 Release of rst_n SHALL take effect on the first rising clk edge after deassertion. No transfer is counted in the reset cycle.

Verification (N_IN=5)
REQ-029 Test 1: after reset, drive req=5'b10100, tail=5'b11111, out_ready=1. Required: select=00100 first, then 10000. The following cycle, with req still 10100, select=00100 again; pkt_cnt=2 after the second grant.
REQ-030 Test 2: req[1] sends a 3-flit packet (tail high on flit 3) while req[0] and req[3] stay high. Required: select=00010 and locked=1 for all 3 flits. After the tail, locked=0 and select=01000 (ptr=2, so input 3 wins); pkt_cnt=1.
REQ-031 Test 3: locked on input 2; deassert req[2] for 4 cycles while req[0]=1. Required: select stays 00100, valid=0, locked=1, and no grant goes to input 0.
REQ-032 Test 4: out_ready=0 for 3 cycles during a locked packet. Required: pkt_cnt, owner, ptr and locked all unchanged; completion proceeds normally once out_ready returns high.
REQ-033 Test 5: assert rst_n=0 midway through a packet from input 4. Required: locked=0 and pkt_cnt=0 immediately. After release, with req=11111, select=00001.
REQ-034 Test 6: preload pkt_cnt toward its limit, CNT_W=4, using 16 single-flit packets. Required: pkt_cnt wraps 15 -> 0 with no other state disturbed.
